inst_fetch: RTL and testbench

INST_FETCH -- requirements
Module: inst_fetch

---
 rtl/inst_fetch_pkg.sv | 27 ++
 rtl/inst_fetch_buf.sv | 71 +++++++
 rtl/inst_fetch.sv | 100 ++++++++++
 tb/tb_inst_fetch.sv | 273 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_fetch_pkg.sv
// Shared CPU-side definitions for the instruction fetch stage:
// fetch FSM encoding, fetch buffer geometry and the buffered entry layout.
package inst_fetch_pkg;

  typedef enum logic [1:0] {
    FETCH_IDLE = 2'd0,
    FETCH_REQ  = 2'd1,
    FETCH_DROP = 2'd2
  } fetch_state_t;

  localparam int FETCH_BUF_DEPTH = 2;
  localparam int FETCH_CNT_W     = $clog2(FETCH_BUF_DEPTH + 1);

  typedef struct packed {
    logic [31:0] inst;
    logic [29:0] pc;
    logic        fault;
  } fetch_entry_t;

  localparam int FETCH_ENTRY_W = $bits(fetch_entry_t);

  // A new request may only be issued while the buffer can still absorb its response.
  function automatic logic has_room(input logic [FETCH_CNT_W-1:0] cnt);
    return cnt < FETCH_CNT_W'(FETCH_BUF_DEPTH);
  endfunction

endpackage

// File: rtl/inst_fetch_buf.sv
// Small circular FIFO used as the fetch buffer; head entry is visible
// combinationally and reads as zero while the buffer is empty.
module fetch_buf #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2,
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             push,
  input  logic             pop,
  input  logic             clear,
  input  logic [WIDTH-1:0] wr_data,
  output logic [CNT_W-1:0] count,
  output logic [CNT_W-1:0] count_next,
  output logic [WIDTH-1:0] head_data
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PTR_W-1:0] bump(input logic [PTR_W-1:0] ptr);
    return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + 1'b1;
  endfunction

  // Clear wins over everything else in the same cycle, including a pop.
  assign do_pop  = pop & ~clear & (count != '0);
  assign do_push = push & ~clear & ((count != CNT_W'(DEPTH)) | do_pop);

  always_comb begin
    count_next = count;
    if (clear) begin
      count_next = '0;
    end else begin
      count_next = count + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (clear) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        wr_ptr <= bump(wr_ptr);
      end
      if (do_pop) begin
        rd_ptr <= bump(rd_ptr);
      end
      count <= count_next;
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  assign head_data = (count != '0) ? mem[rd_ptr] : '0;

endmodule

// File: rtl/inst_fetch.sv
// Instruction fetch stage: issues one outstanding bus read at a time, buffers
// responses for decode and discards in-flight reads across a redirect.
module inst_fetch
  import inst_fetch_pkg::*;
(
  input  logic        clk,
  input  logic        reset_n,
  input  logic [29:0] pc_in,
  output logic        pc_adv,
  input  logic        flush,
  output logic        ibus_req,
  output logic [29:0] ibus_addr,
  input  logic        ibus_ack,
  input  logic [31:0] ibus_rdata,
  input  logic        ibus_err,
  output logic        id_valid,
  input  logic        id_ready,
  output logic [31:0] id_inst,
  output logic [29:0] id_pc,
  output logic        id_fault
);

  fetch_state_t           state;
  logic [29:0]            addr_q;
  logic                   push;
  logic                   pop;
  logic [FETCH_CNT_W-1:0] count;
  logic [FETCH_CNT_W-1:0] count_next;
  fetch_entry_t           push_entry;
  fetch_entry_t           head_entry;

  assign push       = (state == FETCH_REQ) & ibus_ack & ~flush;
  assign pop        = id_valid & id_ready;
  assign pc_adv     = push;
  assign push_entry = '{inst: ibus_rdata, pc: pc_in, fault: ibus_err};

  fetch_buf #(
    .WIDTH (FETCH_ENTRY_W),
    .DEPTH (FETCH_BUF_DEPTH)
  ) u_buf (
    .clk        (clk),
    .reset_n    (reset_n),
    .push       (push),
    .pop        (pop),
    .clear      (flush),
    .wr_data    (push_entry),
    .count      (count),
    .count_next (count_next),
    .head_data  (head_entry)
  );

  // A redirect with a read still pending parks in DROP so the bus keeps a
  // stable request until the stale response arrives and can be thrown away.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= FETCH_IDLE;
      ibus_req <= 1'b0;
      addr_q   <= '0;
    end else begin
      case (state)
        FETCH_REQ: begin
          addr_q <= pc_in;
          if (flush && !ibus_ack) begin
            state    <= FETCH_DROP;
            ibus_req <= 1'b1;
          end else if (flush || has_room(count_next)) begin
            state    <= FETCH_REQ;
            ibus_req <= 1'b1;
          end else begin
            state    <= FETCH_IDLE;
            ibus_req <= 1'b0;
          end
        end
        FETCH_DROP: begin
          ibus_req <= 1'b1;
          if (ibus_ack) begin
            state <= FETCH_REQ;
          end
        end
        default: begin
          if (flush || has_room(count_next)) begin
            state    <= FETCH_REQ;
            ibus_req <= 1'b1;
          end else begin
            state    <= FETCH_IDLE;
            ibus_req <= 1'b0;
          end
        end
      endcase
    end
  end

  assign ibus_addr = (state == FETCH_DROP) ? addr_q : pc_in;

  assign id_valid = (count != '0);
  assign id_inst  = head_entry.inst;
  assign id_pc    = head_entry.pc;
  assign id_fault = head_entry.fault;

endmodule

// File: tb/tb_inst_fetch.sv
// Directed bench for inst_fetch: a queue-based reference model checked every
// cycle, plus hand-computed literal checks at the interesting points.
module tb_inst_fetch;

  localparam logic [29:0] PC_RESET = 30'h2000_3FFC;

  logic        clk;
  logic        reset_n;
  logic [29:0] pc_in;
  logic        pc_adv;
  logic        flush;
  logic        ibus_req;
  logic [29:0] ibus_addr;
  logic        ibus_ack;
  logic [31:0] ibus_rdata;
  logic        ibus_err;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [29:0] id_pc;
  logic        id_fault;
  logic [29:0] redirect;

  int total = 0;
  int bad   = 0;

  inst_fetch dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .pc_in      (pc_in),
    .pc_adv     (pc_adv),
    .flush      (flush),
    .ibus_req   (ibus_req),
    .ibus_addr  (ibus_addr),
    .ibus_ack   (ibus_ack),
    .ibus_rdata (ibus_rdata),
    .ibus_err   (ibus_err),
    .id_valid   (id_valid),
    .id_ready   (id_ready),
    .id_inst    (id_inst),
    .id_pc      (id_pc),
    .id_fault   (id_fault)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Upstream PC register: loads the redirect target on flush, steps on pc_adv.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) pc_in <= PC_RESET;
    else if (flush) pc_in <= redirect;
    else if (pc_adv) pc_in <= pc_in + 30'd1;
  end

  typedef struct {
    logic [31:0] inst;
    logic [29:0] pc;
    logic        fault;
  } ent_t;

  ent_t        m_q[$];
  bit          m_req;
  bit          m_drop;
  logic [29:0] m_addr;
  bit          m_adv;
  bit          m_pop;

  // Reference model: a queue of delivered words, a "request open" flag and a
  // "stale read pending" flag with the address that read was issued to.
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_q.delete();
      m_req  = 1'b0;
      m_drop = 1'b0;
      m_addr = '0;
    end else begin
      m_adv = m_req && !m_drop && ibus_ack && !flush;
      m_pop = (m_q.size() != 0) && id_ready && !flush;
      if (flush) begin
        m_q.delete();
      end else begin
        if (m_pop) void'(m_q.pop_front());
        if (m_adv) m_q.push_back('{ibus_rdata, pc_in, ibus_err});
      end
      if (m_drop) begin
        if (ibus_ack) m_drop = 1'b0;
      end else if (m_req && flush && !ibus_ack) begin
        m_drop = 1'b1;
        m_addr = pc_in;
      end else begin
        m_req = flush || (m_q.size() < 2);
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %h want %h at %0t", name, actual, expected, $time);
    end
  endtask

  always @(negedge clk) begin
    checkOutput("m.req", {31'd0, ibus_req}, {31'd0, m_req});
    checkOutput("m.adv", {31'd0, pc_adv}, {31'd0, m_req && !m_drop && ibus_ack && !flush && reset_n});
    checkOutput("m.valid", {31'd0, id_valid}, {31'd0, m_q.size() != 0});
    if (m_req) checkOutput("m.addr", {2'd0, ibus_addr}, {2'd0, m_drop ? m_addr : pc_in});
    if (m_q.size() != 0) begin
      checkOutput("m.inst", id_inst, m_q[0].inst);
      checkOutput("m.pc", {2'd0, id_pc}, {2'd0, m_q[0].pc});
      checkOutput("m.fault", {31'd0, id_fault}, {31'd0, m_q[0].fault});
    end else if (!reset_n) begin
      checkOutput("rst.id", {id_inst[31:1], id_inst[0] | id_fault | (id_pc != 30'd0)}, 32'd0);
    end
  end

  task automatic applyStimulus(input logic ack, input logic [31:0] rdata, input logic err,
                               input logic fl, input logic rdy, input logic [29:0] tgt);
    ibus_ack   = ack;
    ibus_rdata = rdata;
    ibus_err   = err;
    flush      = fl;
    id_ready   = rdy;
    redirect   = tgt;
    #2;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset_n = 1'b0;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0);
    for (int i = 0; i < 3; i++) begin
      checkOutput("rst.req", {31'd0, ibus_req}, 32'd0);
      checkOutput("rst.valid", {31'd0, id_valid}, 32'd0);
      checkOutput("rst.inst", id_inst, 32'd0);
      tick();
    end
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("post.idle", {31'd0, ibus_req}, 32'd0);
    tick();

    // First fetch after reset
    applyStimulus(1'b1, 32'h3C1A_8000, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t1.req", {31'd0, ibus_req}, 32'd1);
    checkOutput("t1.addr", {2'd0, ibus_addr}, 32'h2000_3FFC);
    checkOutput("t1.adv", {31'd0, pc_adv}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t1.valid", {31'd0, id_valid}, 32'd1);
    checkOutput("t1.inst", id_inst, 32'h3C1A_8000);
    checkOutput("t1.pc", {2'd0, id_pc}, 32'h2000_3FFC);
    checkOutput("t1.adv0", {31'd0, pc_adv}, 32'd0);
    tick();

    // Back-pressure: two pushes then issue stops
    applyStimulus(1'b1, 32'h1111_1111, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t2.addr0", {2'd0, ibus_addr}, 32'h2000_3FFD);
    tick();
    applyStimulus(1'b1, 32'h2222_2222, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t2.adv1", {31'd0, pc_adv}, 32'd1);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b1, 32'h7777_7777, 1'b0, 1'b0, 1'b0, 30'd0);
      checkOutput("t2.stall.req", {31'd0, ibus_req}, 32'd0);
      checkOutput("t2.stall.adv", {31'd0, pc_adv}, 32'd0);
      checkOutput("t2.stall.inst", id_inst, 32'h1111_1111);
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t2.pop.req", {31'd0, ibus_req}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'h3333_3333, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t2.resume.req", {31'd0, ibus_req}, 32'd1);
    checkOutput("t2.resume.addr", {2'd0, ibus_addr}, 32'h2000_3FFF);
    checkOutput("t2.resume.inst", id_inst, 32'h2222_2222);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t2.order.inst", id_inst, 32'h3333_3333);
    checkOutput("t2.order.pc", {2'd0, id_pc}, 32'h2000_3FFF);
    tick();

    // Flush while a read is pending, stale ack three cycles later
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 30'h0010_0000);
    checkOutput("t3.flush.addr", {2'd0, ibus_addr}, 32'h2000_4000);
    tick();
    for (int i = 0; i < 2; i++) begin
      applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0);
      checkOutput("t3.drop.req", {31'd0, ibus_req}, 32'd1);
      checkOutput("t3.drop.addr", {2'd0, ibus_addr}, 32'h2000_4000);
      tick();
    end
    applyStimulus(1'b1, 32'hDEAD_BEEF, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t3.drop.adv", {31'd0, pc_adv}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'hAAAA_0001, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t3.redir.addr", {2'd0, ibus_addr}, 32'h0010_0000);
    checkOutput("t3.redir.valid", {31'd0, id_valid}, 32'd0);
    tick();
    applyStimulus(1'b1, 32'hAAAA_0002, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t3.next.addr", {2'd0, ibus_addr}, 32'h0010_0001);
    tick();

    // Flush with a full buffer and an ack in the same cycle
    applyStimulus(1'b1, 32'h9999_9999, 1'b0, 1'b1, 1'b1, 30'h0020_0000);
    checkOutput("t4.full.adv", {31'd0, pc_adv}, 32'd0);
    checkOutput("t4.full.inst", id_inst, 32'hAAAA_0001);
    tick();
    applyStimulus(1'b1, 32'h8888_8888, 1'b0, 1'b1, 1'b0, 30'h0030_0000);
    checkOutput("t4.empty.valid", {31'd0, id_valid}, 32'd0);
    checkOutput("t4.req.addr", {2'd0, ibus_addr}, 32'h0020_0000);
    checkOutput("t4.ackflush.adv", {31'd0, pc_adv}, 32'd0);
    tick();

    // Bus fault carried with its entry
    applyStimulus(1'b1, 32'hBADB_AD00, 1'b1, 1'b0, 1'b0, 30'd0);
    checkOutput("t5.addr", {2'd0, ibus_addr}, 32'h0030_0000);
    checkOutput("t5.adv", {31'd0, pc_adv}, 32'd1);
    tick();
    applyStimulus(1'b1, 32'h1234_5678, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t5.fault", {31'd0, id_fault}, 32'd1);
    checkOutput("t5.inst", id_inst, 32'hBADB_AD00);
    checkOutput("t5.next.adv", {31'd0, pc_adv}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t5.clean", {31'd0, id_fault}, 32'd0);
    checkOutput("t5.pc", {2'd0, id_pc}, 32'h0030_0001);
    tick();

    // Streaming at one instruction per cycle
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, 32'hC000_0000 + 32'(i), 1'b0, 1'b0, 1'b1, 30'd0);
      checkOutput("tp.adv", {31'd0, pc_adv}, 32'd1);
      if (i > 0) checkOutput("tp.inst", id_inst, 32'hC000_0000 + 32'(i - 1));
      tick();
    end
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    tick();

    // Reset in the middle of a dropped read
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 30'h0040_0000);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t6.drop.req", {31'd0, ibus_req}, 32'd1);
    reset_n = 1'b0;
    #1;
    checkOutput("t6.rst.req", {31'd0, ibus_req}, 32'd0);
    checkOutput("t6.rst.valid", {31'd0, id_valid}, 32'd0);
    tick();
    tick();
    reset_n = 1'b1;
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 30'd0);
    tick();
    applyStimulus(1'b1, 32'h55AA_55AA, 1'b0, 1'b0, 1'b0, 30'd0);
    checkOutput("t6.fresh.addr", {2'd0, ibus_addr}, 32'h2000_3FFC);
    checkOutput("t6.fresh.adv", {31'd0, pc_adv}, 32'd1);
    tick();
    applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b1, 30'd0);
    checkOutput("t6.fresh.inst", id_inst, 32'h55AA_55AA);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
